udma_i2s_rx_packer: RTL and testbench
=====================================

// Module: udma_i2s_rx_packer
// PURPOSE
//  Sits in sys_clk domain between the RX dual-clock FIFO output and the uDMA RX channel.
//  Formats each received I2S/PDM sample to the programmed element size (8/16/32 bit).
//  Packs elements little-endian into 32-bit uDMA words, resyncing stereo L/R order.
//  Supports flush of partial words and a pass-through mode.
// PARAMETERS
//  none (all widths fixed by the uDMA RX channel: 32-bit data, 2-bit datasize)
// PORTS
//  clk_i               in   1   system clock; the only clock
//  rst_i               in   1   reset, synchronous, active-high
//  cfg_en_i            in   1   block enable; low = drop partial word, in_ready_o=0
//  cfg_pack_en_i       in   1   1 = pack to 32-bit words, 0 = one element per output
//  cfg_datasize_i      in   2   element size: 00=8, 01=16, 10/11=32 bit
//  cfg_bits_word_i     in   5   input sample width minus 1 (W = value+1)
//  cfg_2ch_i           in   1   stereo: word must start with left (ch 0) element
//  cfg_signed_i        in   1   sign-extend narrow samples (only with macro, below)
//  cfg_flush_i         in   1   pulse: emit partial word zero-padded
//  cfg_clr_i           in   1   pulse: discard partial word and pending flush
//  in_data_i           in   32  sample, right-justified, W valid bits
//  in_ch_i             in   1   sample channel (0=left, 1=right)
//  in_valid_i          in   1   sample valid
//  in_ready_o          out  1   sample accepted when valid & ready
//  data_rx_o           out  32  word to uDMA
//  data_rx_datasize_o  out  2   10 when packing, else cfg_datasize_i
//  data_rx_valid_o     out  1   output valid; held with stable data until ready
//  data_rx_ready_i     in   1   uDMA ready
//  sync_err_o          out  1   1-cycle pulse: out-of-order right sample dropped
//  busy_o              out  1   partial word held or flush pending
// BEHAVIOUR
//  Reset: all outputs 0, accumulator empty, element index 0, FSM IDLE.
//  FSM: IDLE (cfg_en_i=0) -> RUN on cfg_en_i=1; RUN -> FLUSH on cfg_flush_i;
//   FLUSH -> RUN once partial word moved to output reg (or immediately if empty);
//   any state -> IDLE on cfg_en_i=0 (partial dropped, output reg still drains).
//  Formatting (E = element bits): W>E keeps top E bits; W<E extends at top; W=E as is.
//  Packing: element k (0..32/E-1) placed at bits [k*E +: E]; word complete at k=32/E-1.
//  Pass-through (cfg_pack_en_i=0): each element is one output word, right-justified.
//  Latency: 1 cycle from completing input handshake to data_rx_valid_o.
//  in_ready_o = RUN & (!word_completes | !data_rx_valid_o | data_rx_ready_i).
//  Backpressure: no sample lost or duplicated; output reg loads same cycle it drains.
//  Stereo: cfg_2ch_i=1, k=0 and in_ch_i=1 -> sample accepted, discarded, sync_err_o.
//  Flush cycle: sample accepted in same cycle as cfg_flush_i is included before flush.
//  Flush with k=0: no output. In FLUSH, in_ready_o=0. Unused bytes padded with 0.
//  cfg_clr_i beats cfg_flush_i in same cycle; clear does not affect output reg.
//  Config changes legal only while busy_o=0 or cfg_en_i=0.
// CONFIGURATION
//  I2S_RX_PACK_SIGN_EXT_EN defined: W<E with cfg_signed_i=1 sign-extends from bit W-1.
//  Not defined: always zero-extend; cfg_signed_i ignored (port kept).
// STRUCTURE
//  udma_i2s_pkg: datasize_e enum (DS_8, DS_16, DS_32), packer_state_e, ELEM_PER_WORD consts.
//  Sub-module udma_i2s_elem_fmt: combinational W->E truncate/extend formatter.
//  Top: FSM, element index counter, 32-bit accumulator, output register.
// TESTING
//  Pack 8: W=16, DS 00, samples 1234,5678,9ABC,DEF0 -> one word 0xDE9A5612, ds=10.
//  Ext 16: W=12, DS 01, signed, 0x800,0x001 -> 0x0001F800 (macro), 0x00010800 (no macro).
//  Stereo: 2ch, DS 01, W=16, R=0x1111 first -> dropped, sync_err 1 cycle; L=0xAAAA, R=0xBBBB -> 0xBBBBAAAA.
//  Flush: DS 00, W=8, 0x11,0x22,0x33 then flush -> 0x00332211 once; flush when empty -> nothing.
//  Backpressure: ready low 5 cycles during 16 samples DS 00 -> exactly 4 words, in order, stable while stalled.
//  Reset/clear mid-word: 2 of 4 bytes then rst_i or cfg_clr_i -> no output; next 4 bytes form clean word.

Source files
------------

// File: rtl/udma_i2s_rx_packer_pkg.sv
// Shared types and helpers for the uDMA I2S RX packer.
// Element size decode, FSM state type and per-size packing constants.
package udma_i2s_pkg;

  typedef enum logic [1:0] {
    DS_8  = 2'b00,
    DS_16 = 2'b01,
    DS_32 = 2'b10
  } datasize_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } packer_state_e;

  localparam int unsigned ELEM_PER_WORD_8  = 4;
  localparam int unsigned ELEM_PER_WORD_16 = 2;
  localparam int unsigned ELEM_PER_WORD_32 = 1;

  // Raw 2-bit datasize to element size; 10 and 11 both mean 32 bit.
  function automatic datasize_e decode_ds(input logic [1:0] raw);
    case (raw)
      2'b00:   return DS_8;
      2'b01:   return DS_16;
      default: return DS_32;
    endcase
  endfunction

  // Element width in bits.
  function automatic logic [5:0] elem_bits(input datasize_e ds);
    case (ds)
      DS_8:    return 6'd8;
      DS_16:   return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  // Index of the element that completes a 32-bit word.
  function automatic logic [1:0] last_idx(input datasize_e ds);
    case (ds)
      DS_8:    return 2'(ELEM_PER_WORD_8 - 1);
      DS_16:   return 2'(ELEM_PER_WORD_16 - 1);
      default: return 2'(ELEM_PER_WORD_32 - 1);
    endcase
  endfunction

  // Bit offset of element k inside the word (k*E).
  function automatic logic [4:0] elem_shamt(input datasize_e ds, input logic [1:0] k);
    case (ds)
      DS_8:    return {k, 3'b000};
      DS_16:   return {k[0], 4'b0000};
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/udma_i2s_rx_packer_elem_fmt.sv
// Combinational sample formatter: W-bit right-justified sample to E-bit element.
// W>E keeps the top E bits, W<E extends at the top, W=E passes unchanged.
// Optional I2S_RX_PACK_SIGN_EXT_EN: sign-extend from bit W-1 when signed_i=1.
module udma_i2s_elem_fmt
  import udma_i2s_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [4:0]  bits_word_i,
  input  datasize_e   ds_i,
  input  logic        signed_i,
  output logic [31:0] elem_o
);

  logic [5:0]  w;
  logic [5:0]  e;
  logic [31:0] mask_w;
  logic [31:0] mask_e;
  logic [31:0] raw;

`ifndef I2S_RX_PACK_SIGN_EXT_EN
  logic unused_signed;
  assign unused_signed = signed_i;
`endif

  // Truncate or extend the sample to the element size.
  always_comb begin
    w      = {1'b0, bits_word_i} + 6'd1;
    e      = elem_bits(ds_i);
    mask_w = (bits_word_i == 5'd31) ? '1 : ((32'd1 << w) - 32'd1);
    case (ds_i)
      DS_8:    mask_e = 32'h0000_00FF;
      DS_16:   mask_e = 32'h0000_FFFF;
      default: mask_e = '1;
    endcase
    raw    = data_i & mask_w;
    elem_o = raw;
    if (w > e) begin
      elem_o = (raw >> (w - e)) & mask_e;
    end
`ifdef I2S_RX_PACK_SIGN_EXT_EN
    else if (signed_i && raw[bits_word_i]) begin
      elem_o = raw | (mask_e & ~mask_w);
    end
`endif
  end

endmodule

// File: rtl/udma_i2s_rx_packer.sv
// uDMA I2S RX packer: formats samples to 8/16/32-bit elements and packs them
// little-endian into 32-bit words, with stereo resync, flush and pass-through.
// Optional feature macro: I2S_RX_PACK_SIGN_EXT_EN (sign extension of narrow samples).
module udma_i2s_rx_packer
  import udma_i2s_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_en_i,
  input  logic        cfg_pack_en_i,
  input  logic [1:0]  cfg_datasize_i,
  input  logic [4:0]  cfg_bits_word_i,
  input  logic        cfg_2ch_i,
  input  logic        cfg_signed_i,
  input  logic        cfg_flush_i,
  input  logic        cfg_clr_i,
  input  logic [31:0] in_data_i,
  input  logic        in_ch_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [31:0] data_rx_o,
  output logic [1:0]  data_rx_datasize_o,
  output logic        data_rx_valid_o,
  input  logic        data_rx_ready_i,
  output logic        sync_err_o,
  output logic        busy_o
);

  packer_state_e state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic [1:0]    out_ds_q, out_ds_d;
  logic          sync_err_q, sync_err_d;

  datasize_e     ds;
  logic [31:0]   elem;
  logic [31:0]   merged;
  logic          drop;
  logic          completes;
  logic          out_free;
  logic          accept;

  assign ds = decode_ds(cfg_datasize_i);

  udma_i2s_elem_fmt u_fmt (
    .data_i      (in_data_i),
    .bits_word_i (cfg_bits_word_i),
    .ds_i        (ds),
    .signed_i    (cfg_signed_i),
    .elem_o      (elem)
  );

  // A right sample arriving where a word must start is consumed and discarded.
  assign drop      = cfg_2ch_i & (idx_q == 2'd0) & in_ch_i;
  assign completes = ~drop & (cfg_pack_en_i ? (idx_q == last_idx(ds)) : 1'b1);
  assign out_free  = ~out_valid_q | data_rx_ready_i;
  assign in_ready_o = cfg_en_i & (state_q == ST_RUN) & (~completes | out_free);
  assign accept    = in_valid_i & in_ready_o;
  assign merged    = acc_q | (elem << elem_shamt(ds, idx_q));

  // Next-state: FSM, accumulator, element index and output register.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_ds_d    = out_ds_q;
    sync_err_d  = 1'b0;

    if (out_valid_q && data_rx_ready_i) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_en_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (accept) begin
          if (drop) begin
            sync_err_d = 1'b1;
          end else if (completes) begin
            out_d       = cfg_pack_en_i ? merged : elem;
            out_ds_d    = cfg_pack_en_i ? 2'b10 : cfg_datasize_i;
            out_valid_d = 1'b1;
            acc_d       = '0;
            idx_d       = '0;
          end else begin
            acc_d = merged;
            idx_d = idx_q + 2'd1;
          end
        end
        // The sample accepted this cycle is already merged before flushing.
        if (cfg_flush_i && !cfg_clr_i) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (cfg_clr_i || idx_q == 2'd0) begin
          state_d = ST_RUN;
        end else if (out_free) begin
          out_d       = acc_q;
          out_ds_d    = 2'b10;
          out_valid_d = 1'b1;
          acc_d       = '0;
          idx_d       = '0;
          state_d     = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cfg_clr_i) begin
      acc_d = '0;
      idx_d = '0;
    end

    // Disable drops the partial word; the output register keeps draining.
    if (!cfg_en_i) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      idx_d   = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_ds_q    <= '0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_ds_q    <= out_ds_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign data_rx_o          = out_q;
  assign data_rx_datasize_o = out_ds_q;
  assign data_rx_valid_o    = out_valid_q;
  assign sync_err_o         = sync_err_q;
  assign busy_o             = (idx_q != 2'd0) | (state_q == ST_FLUSH);

endmodule

// File: tb/tb_udma_i2s_rx_packer.sv
// Scoreboard bench for udma_i2s_rx_packer: directed scenarios plus random traffic.
module tb_udma_i2s_rx_packer;

  logic        clk = 1'b0;
  logic        rst_i, cfg_en_i, cfg_pack_en_i, cfg_2ch_i, cfg_signed_i;
  logic        cfg_flush_i, cfg_clr_i, in_ch_i, in_valid_i, in_ready_o;
  logic [1:0]  cfg_datasize_i, data_rx_datasize_o;
  logic [4:0]  cfg_bits_word_i;
  logic [31:0] in_data_i, data_rx_o;
  logic        data_rx_valid_o, data_rx_ready_i, sync_err_o, busy_o;

  udma_i2s_rx_packer dut (
    .clk_i(clk), .rst_i(rst_i), .cfg_en_i(cfg_en_i), .cfg_pack_en_i(cfg_pack_en_i),
    .cfg_datasize_i(cfg_datasize_i), .cfg_bits_word_i(cfg_bits_word_i),
    .cfg_2ch_i(cfg_2ch_i), .cfg_signed_i(cfg_signed_i), .cfg_flush_i(cfg_flush_i),
    .cfg_clr_i(cfg_clr_i), .in_data_i(in_data_i), .in_ch_i(in_ch_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .data_rx_o(data_rx_o),
    .data_rx_datasize_o(data_rx_datasize_o), .data_rx_valid_o(data_rx_valid_o),
    .data_rx_ready_i(data_rx_ready_i), .sync_err_o(sync_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

`ifdef I2S_RX_PACK_SIGN_EXT_EN
  localparam logic [31:0] EXT_EXP = 32'h0001_F800;
`else
  localparam logic [31:0] EXT_EXP = 32'h0001_0800;
`endif

  typedef struct { logic [31:0] d; logic [1:0] ds; } exp_t;
  exp_t              sb[$];
  longint unsigned   pend[$];
  int                checks = 0, failures = 0;
  int                exp_sync = 0, sync_cnt = 0, words = 0;
  int                rdy_mode = 0;  // 0 always ready, 1 random, 2 held low
  logic [31:0]       last_word = '0;
  logic [1:0]        last_ds = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: element size and formatting from plain arithmetic.
  function automatic int ebits(input logic [1:0] ds);
    return (ds == 2'b00) ? 8 : (ds == 2'b01) ? 16 : 32;
  endfunction

  function automatic longint unsigned ref_fmt(input logic [31:0] v);
    int w = int'(cfg_bits_word_i) + 1;
    int e = ebits(cfg_datasize_i);
    longint unsigned x = longint'(v) % (64'd1 << w);
    if (w > e) x = x / (64'd1 << (w - e));
`ifdef I2S_RX_PACK_SIGN_EXT_EN
    else if (w < e && cfg_signed_i && ((x >> (w - 1)) % 2 == 1))
      x = x + (64'd1 << e) - (64'd1 << w);
`endif
    return x;
  endfunction

  function automatic logic [31:0] pend_word();
    longint unsigned s = 0;
    int e = ebits(cfg_datasize_i);
    foreach (pend[i]) s += pend[i] << (i * e);
    return s[31:0];
  endfunction

  function automatic void model_add(input logic [31:0] d, input logic ch);
    longint unsigned el;
    exp_t x;
    if (cfg_2ch_i && pend.size() == 0 && ch) begin
      exp_sync++;
      return;
    end
    el = ref_fmt(d);
    if (!cfg_pack_en_i) begin
      x.d = el[31:0]; x.ds = cfg_datasize_i; sb.push_back(x);
    end else begin
      pend.push_back(el);
      if (pend.size() == 32 / ebits(cfg_datasize_i)) begin
        x.d = pend_word(); x.ds = 2'b10; sb.push_back(x);
        pend.delete();
      end
    end
  endfunction

  function automatic void model_flush();
    exp_t x;
    if (pend.size() > 0) begin
      x.d = pend_word(); x.ds = 2'b10; sb.push_back(x);
    end
    pend.delete();
  endfunction

  // Output monitor: drives ready, pops the scoreboard on handshake, checks stability.
  logic        held = 1'b0;
  logic [31:0] held_d;
  logic [1:0]  held_ds;
  always @(negedge clk) begin
    logic r;
    exp_t x;
    r = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    data_rx_ready_i = r;
    if (sync_err_o) sync_cnt++;
    if (data_rx_valid_o) begin
      if (held) begin
        chk("stall_data", data_rx_o, held_d);
        chk("stall_ds", {30'd0, data_rx_datasize_o}, {30'd0, held_ds});
      end
      if (r) begin
        held = 1'b0;
        words++;
        last_word = data_rx_o;
        last_ds = data_rx_datasize_o;
        if (sb.size() == 0) begin
          chk("unexpected_word", data_rx_o, 32'hxxxx_xxxx);
        end else begin
          x = sb.pop_front();
          chk("word", data_rx_o, x.d);
          chk("word_ds", {30'd0, data_rx_datasize_o}, {30'd0, x.ds});
        end
      end else begin
        held = 1'b1; held_d = data_rx_o; held_ds = data_rx_datasize_o;
      end
    end else begin
      if (held) chk("valid_dropped_while_stalled", 32'd0, 32'd1);
      held = 1'b0;
    end
  end

  task automatic send(input logic [31:0] d, input logic ch, input bit fl);
    bit acc = 0;
    bit first = 1;
    int n = 0;
    while (!acc) begin
      @(negedge clk);
      in_data_i = d; in_ch_i = ch; in_valid_i = 1'b1;
      cfg_flush_i = fl & first;
      #1 acc = in_ready_o;
      @(posedge clk);
      if (acc) model_add(d, ch);
      if (fl && first) model_flush();
      first = 0;
      #1 in_valid_i = 1'b0; cfg_flush_i = 1'b0;
      if (++n > 500) begin
        chk("send_timeout", 32'd0, 32'd1);
        return;
      end
    end
  endtask

  task automatic do_flush();
    @(negedge clk); cfg_flush_i = 1'b1;
    @(posedge clk); model_flush();
    #1 cfg_flush_i = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk); cfg_clr_i = 1'b1;
    @(posedge clk); pend.delete();
    #1 cfg_clr_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || data_rx_valid_o) && n < 1000) begin
      @(negedge clk); n++;
    end
    if (n >= 1000) chk("drain_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic set_cfg(input logic pk, input logic [1:0] ds, input logic [4:0] bw,
                         input logic c2, input logic sg);
    drain();
    @(negedge clk);
    cfg_pack_en_i = pk; cfg_datasize_i = ds; cfg_bits_word_i = bw;
    cfg_2ch_i = c2; cfg_signed_i = sg; cfg_en_i = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int w0;
    rst_i = 1; cfg_en_i = 0; cfg_pack_en_i = 0; cfg_datasize_i = 0; cfg_bits_word_i = 0;
    cfg_2ch_i = 0; cfg_signed_i = 0; cfg_flush_i = 0; cfg_clr_i = 0;
    in_data_i = 0; in_ch_i = 0; in_valid_i = 0; data_rx_ready_i = 1;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, data_rx_valid_o}, 32'd0);
    chk("rst_data", data_rx_o, 32'd0);
    chk("rst_ds", {30'd0, data_rx_datasize_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_sync_err", {31'd0, sync_err_o}, 32'd0);
    rst_i = 0;
    repeat (2) @(negedge clk);
    chk("disabled_ready", {31'd0, in_ready_o}, 32'd0);

    // Pack 8 from 16-bit samples.
    set_cfg(1, 2'b00, 5'd15, 0, 0);
    send(32'h1234, 0, 0); send(32'h5678, 0, 0); send(32'h9ABC, 0, 0); send(32'hDEF0, 0, 0);
    drain();
    chk("pack8_word", last_word, 32'hDE9A_5612);
    chk("pack8_ds", {30'd0, last_ds}, 32'd2);

    // 12-bit samples into 16-bit elements, signed.
    set_cfg(1, 2'b01, 5'd11, 0, 1);
    send(32'h800, 0, 0); send(32'h001, 0, 0);
    drain();
    chk("ext16_word", last_word, EXT_EXP);

    // Stereo resync.
    set_cfg(1, 2'b01, 5'd15, 1, 0);
    send(32'h1111, 1, 0); send(32'hAAAA, 0, 0); send(32'hBBBB, 1, 0);
    drain();
    chk("stereo_word", last_word, 32'hBBBB_AAAA);
    chk("stereo_sync_cnt", sync_cnt, 32'd1);

    // Flush partial word, then flush with nothing held.
    set_cfg(1, 2'b00, 5'd7, 0, 0);
    w0 = words;
    send(32'h11, 0, 0); send(32'h22, 0, 0); send(32'h33, 0, 0);
    chk("busy_partial", {31'd0, busy_o}, 32'd1);
    do_flush(); drain();
    chk("flush_word", last_word, 32'h0033_2211);
    chk("flush_count", words - w0, 32'd1);
    do_flush(); repeat (5) @(negedge clk); drain();
    chk("flush_empty_count", words - w0, 32'd1);
    chk("busy_after_flush", {31'd0, busy_o}, 32'd0);

    // Backpressure: ready held low for 5 cycles during 16 byte samples.
    w0 = words;
    rdy_mode = 2;
    fork
      for (int i = 0; i < 16; i++) send($urandom_range(0, 255), 0, 0);
      begin repeat (5) @(negedge clk); rdy_mode = 0; end
    join
    drain();
    chk("bp_count", words - w0, 32'd4);

    // Reset mid-word, then a clean word.
    w0 = words;
    send(32'hA1, 0, 0); send(32'hA2, 0, 0);
    drain();
    @(negedge clk); rst_i = 1;
    @(negedge clk); rst_i = 0; pend.delete();
    send(32'h44, 0, 0); send(32'h55, 0, 0); send(32'h66, 0, 0); send(32'h77, 0, 0);
    drain();
    chk("rst_mid_word", last_word, 32'h7766_5544);
    chk("rst_mid_count", words - w0, 32'd1);

    // Clear mid-word, then a clean word.
    w0 = words;
    send(32'hB1, 0, 0); send(32'hB2, 0, 0);
    do_clear();
    send(32'h01, 0, 0); send(32'h02, 0, 0); send(32'h03, 0, 0); send(32'h04, 0, 0);
    drain();
    chk("clr_mid_word", last_word, 32'h0403_0201);
    chk("clr_mid_count", words - w0, 32'd1);

    // Random configurations and traffic with random output backpressure.
    rdy_mode = 1;
    for (int t = 0; t < 16; t++) begin
      int n;
      set_cfg(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n = $urandom_range(8, 40);
      for (int i = 0; i < n; i++)
        send($urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      do_flush();
      drain();
    end
    rdy_mode = 0;
    drain();

    chk("scoreboard_empty", sb.size(), 32'd0);
    chk("sync_err_total", sync_cnt, exp_sync);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
